// File: rtl/fft_pkg.sv
// Shared FFT constants, reader state encoding and address helpers.
// Used by the address generator, butterfly write path and result reader.
package fft_pkg;

  localparam int N_LOG2 = 5;
  localparam int N      = 1 << N_LOG2;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

  function automatic logic [N_LOG2-1:0] bitrev(
    input logic [N_LOG2-1:0] k
  );
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = k[N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_reader_skid.sv
// Two-entry FIFO that holds returning memory words for the output stream.
// Occupancy is exported so the reader can meter its read credits.
module skid_fifo_2 #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i & (cnt_q != 2'd0);
  assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;

  // Storage, pointers and count; clear empties everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// Streams the final FFT bank out in natural bin order.
// Reads bit-reversed addresses, metered by a 2-word credit.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int N_LOG2 = fft_pkg::N_LOG2,
  parameter int DATA_W = fft_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              fft_done,
  input  logic              bank_select,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr,
  output logic              rd_bank,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              read_done
);

  localparam int W = 1 + N_LOG2 + DATA_W;
  localparam logic [N_LOG2-1:0] KMAX = '1;

  rd_state_e         state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic [N_LOG2-1:0] tag_q;
  logic [N_LOG2-1:0] rev;
  logic              bank_q, bank_d;
  logic              done_q;
  logic              infl_q;
  logic              trig;
  logic              pop;
  logic              credit_ok;
  logic [1:0]        occ;
  logic [W-1:0]      fifo_din;
  logic [W-1:0]      fifo_dout;

  assign trig = fft_done & ~done_q;
  assign pop  = out_valid & out_ready;

  assign credit_ok = ({1'b0, occ} + {2'b0, infl_q})
                   < (3'd2 + {2'b0, pop});

  // Bit-reverse the issue counter to form the read address.
  always_comb begin
    rev = '0;
    for (int i = 0; i < N_LOG2; i++) begin
      rev[i] = k_q[N_LOG2-1-i];
    end
  end

  assign rd_en     = (state_q == READ) & credit_ok;
  assign rd_addr   = rd_en ? rev : '0;
  assign rd_bank   = bank_q;
  assign busy      = (state_q == READ) | (state_q == DRAIN);
  assign read_done = (state_q == DONE);

  assign fifo_din = {(tag_q == KMAX), tag_q, rd_data};

  skid_fifo_2 #(
    .W(W)
  ) u_skid (
    .clk    (clk),
    .clr    (clr),
    .push_i (infl_q),
    .din_i  (fifo_din),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .valid_o(out_valid),
    .count_o(occ)
  );

  assign out_last  = fifo_dout[W-1];
  assign out_index = fifo_dout[W-2 -: N_LOG2];
  assign out_data  = fifo_dout[DATA_W-1:0];

  // Next state, issue counter and bank latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    bank_d  = bank_q;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = READ;
          k_d     = '0;
          bank_d  = bank_select;
        end
      end
      READ: begin
        if (rd_en) begin
          k_d = k_q + 1'b1;
          if (k_q == KMAX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop & out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, edge-detect copy, in-flight flag and read tag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      k_q     <= '0;
      bank_q  <= 1'b0;
      done_q  <= 1'b0;
      infl_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      bank_q  <= bank_d;
      done_q  <= fft_done;
      infl_q  <= rd_en;
      if (rd_en) begin
        tag_q <= k_q;
      end
    end
  end

endmodule

// File: doc/fft_result_reader.md
# fft_result_reader

Streams the 32 complex results of a finished radix-2 FFT out of the ping-pong result memory after the address generator raises `fft_done`. It reads the final bank in bit-reversed address order and presents the results in natural bin order on a valid/ready stream. It is the read-side counterpart of the address generator and butterfly write path. It owns the memory read port while `busy` is high.

## Interface
- `N_LOG2`, default 5: log2 of the FFT length; address width.
- `DATA_W`, default 32: complex word width ({re[15:0], im[15:0]}); passed through unmodified.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `fft_done` in 1: level from the address generator; a rising edge starts a readout.
- `bank_select` in 1: bank holding the final results; sampled on the trigger cycle.
- `rd_en` out 1: memory read strobe.
- `rd_addr` out N_LOG2: memory read address.
- `rd_bank` out 1: bank being read.
- `rd_data` in DATA_W: memory read data, valid exactly 1 cycle after `rd_en`.
- `out_data` out DATA_W: result word.
- `out_index` out N_LOG2: natural-order bin number of `out_data`.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `out_last` out 1: high with bin N-1.
- `busy` out 1: readout in progress.
- `read_done` out 1: one-cycle pulse after bin N-1 is accepted.

## Operation
- FSM states:
  - IDLE
  - READ: issuing reads.
  - DRAIN: all reads issued, buffer not yet empty.
  - DONE: 1 cycle, `read_done`=1.
  - DONE then returns to IDLE.
- Trigger: `fft_done`=1 while its registered copy is 0. In IDLE this moves to READ.
  - The issue counter `k` and the bank latch are loaded on the trigger cycle: `k`←0, `rd_bank`←`bank_select`.
  - Edges seen outside IDLE are ignored.
  - A held-high `fft_done` causes exactly one readout.
- Addressing: `rd_addr` = bitrev(`k`) over N_LOG2 bits.
  - The tag `k` travels with the read and appears on `out_index`.
  - `k` increments on each `rd_en`.
  - READ moves to DRAIN when `rd_en` is issued with `k`=N-1.
- Credit rule: `rd_en` is issued only when occupancy + in-flight − pop < 2.
  - occupancy is the number of entries in the 2-entry output buffer.
  - in-flight is 0 or 1.
  - pop is `out_valid & out_ready` in this cycle.
  - The returning word is never dropped and never overwrites an entry.
- Stream rules:
  - `out_data`, `out_index` and `out_last` hold stable while `out_valid=1 & out_ready=0`.
  - `out_valid` never drops without a handshake, except on `clr`.
- DRAIN moves to DONE on the handshake with `out_last`=1.
- `busy`=1 in READ and DRAIN.
- `clr` at any time:
  - next state IDLE; buffer and in-flight flag emptied.
  - the registered copy of `fft_done` is loaded with 0.
  - all outputs 0.
  - rd_data returning after `clr` is discarded.
- Reset values: every output is 0.

## Timing
- Let the trigger be in cycle t.
  - First `rd_en` (addr 0) is in t+1.
  - `rd_data` returns in t+2 and is written into the buffer.
  - `out_valid`=1 from t+3 (registered output).
- With `out_ready` held at 1:
  - throughput is 1 word/cycle, and `rd_en` is high t+1..t+32 with addresses 0,16,8,24,4,…,31.
  - out_index 0..31 appear in t+3..t+34; `out_last` in t+34.
  - `read_done` in t+35; `busy` low from t+35.
- Backpressure: once 2 words are held or in flight, `rd_en` stays low until a pop occurs.
  - The pop cycle may issue a read.
  - Resumption adds no bubble beyond the memory latency.
- The latch of `bank_select` is 0-latency; later changes of `bank_select` have no effect until the next trigger.

## Structure
- Shared package `fft_pkg`:
  - `N_LOG2`, `N`, `DATA_W`.
  - the reader state enum {IDLE, READ, DRAIN, DONE}.
  - function `bitrev(k)`.
  - The address generator uses the same constants.
- Sub-module `skid_fifo_2`: a 2-entry FIFO of {`out_last`, `out_index`, data}.
  - It has synchronous clear and exposes occupancy to the credit logic.
- The top level holds the FSM, the edge detect, the counter, the bank latch and the in-flight flag.

## Test plan
- Free-flowing readout: memory word at address a = 0x1000_0000+a, `out_ready`=1, trigger at t.
  - `rd_addr` sequence 0,16,8,24,…,15,31.
  - out_index 0..31 with `out_data` = 0x1000_0000+bitrev(index).
  - `out_last` only at 31, `read_done` at t+35.
- Backpressure: drop `out_ready` for 5 cycles when index 7 is presented.
  - index 7 holds stable.
  - at most 2 words are buffered or in flight.
  - `rd_en` stays low while stalled.
  - no loss or duplication; indices 0..31 are each delivered exactly once.
- Bank latch: `bank_select`=1 at trigger, toggled every cycle during READ.
  - `rd_bank`=1 throughout.
  - next readout with `bank_select`=0 gives `rd_bank`=0.
- Mid-operation `clr` while index 12 is presented.
  - the next cycle shows IDLE with all outputs 0.
  - a fresh `fft_done` edge restarts from `rd_addr` 0 and index 0.
- Trigger filtering: `fft_done` held high for 100 cycles gives exactly one readout.
  - a second pulse during READ is ignored.
  - a pulse after `read_done` starts a second full readout.
